// File: rtl/pwm_timebase_ctrl_if.sv
// Connection bundle between the PWM register file and the timebase/update
// sequencer: timebase controls and staged channel values go in, the period
// count, qualifiers and active channel registers come back out.
interface pwm_timebase_ctrl_if #(
    parameter int PWM_NUM    = 8,
    parameter int APB_DWIDTH = 8
);
    logic                             timebase_en;
    logic [APB_DWIDTH-1:0]            prescale_reg;
    logic [APB_DWIDTH-1:0]            period_reg;
    logic                             update_mode;
    logic                             sync_update_req;
    logic [PWM_NUM-1:0]               stg_enable;
    logic [PWM_NUM*APB_DWIDTH-1:0]    stg_posedge;
    logic [PWM_NUM*APB_DWIDTH-1:0]    stg_negedge;

    logic [APB_DWIDTH-1:0]            period_cnt;
    logic                             sync_pulse;
    logic                             period_end;
    logic [PWM_NUM-1:0]               pwm_enable_reg;
    logic [PWM_NUM*APB_DWIDTH-1:0]    pwm_posedge_reg;
    logic [PWM_NUM*APB_DWIDTH-1:0]    pwm_negedge_reg;
    logic                             update_pending;

    // Register file side
    modport master (
        output timebase_en, prescale_reg, period_reg, update_mode,
               sync_update_req, stg_enable, stg_posedge, stg_negedge,
        input  period_cnt, sync_pulse, period_end, pwm_enable_reg,
               pwm_posedge_reg, pwm_negedge_reg, update_pending
    );

    // Timebase controller side
    modport slave (
        input  timebase_en, prescale_reg, period_reg, update_mode,
               sync_update_req, stg_enable, stg_posedge, stg_negedge,
        output period_cnt, sync_pulse, period_end, pwm_enable_reg,
               pwm_posedge_reg, pwm_negedge_reg, update_pending
    );
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase and register-update sequencer. Generates the prescaled
// sync_pulse and the free-running period counter, and owns the active copies
// of the channel enable/edge registers, loading them from the staged values
// either every cycle or only at a period boundary so duty changes never glitch.
module pwm_timebase_ctrl #(
    parameter int PWM_NUM    = 8,
    parameter int APB_DWIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    pwm_timebase_ctrl_if.slave   bus
);
    localparam logic [APB_DWIDTH-1:0] CNT_ZERO = {APB_DWIDTH{1'b0}};
    localparam logic [APB_DWIDTH-1:0] CNT_ONE  = {{(APB_DWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } tb_state_t;

    tb_state_t                     state_r;
    tb_state_t                     state_nxt_s;
    logic                          run_s;
    logic                          stopped_s;
    logic                          period_end_s;
    logic                          load_s;
    logic                          pending_nxt_s;

    logic [APB_DWIDTH-1:0]         prescale_cnt_r;
    logic [APB_DWIDTH-1:0]         period_cnt_r;
    logic                          sync_pulse_r;
    logic                          update_pending_r;
    logic [PWM_NUM-1:0]            enable_r;
    logic [PWM_NUM*APB_DWIDTH-1:0] posedge_r;
    logic [PWM_NUM*APB_DWIDTH-1:0] negedge_r;

    // Timebase state register: RUNNING tracks timebase_en one edge late
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r <= ST_STOPPED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus run/stop qualifiers; dropping the enable stops the counters on the very next edge
    always_comb begin
        state_nxt_s = ST_STOPPED;
        run_s       = 1'b0;
        stopped_s   = 1'b1;
        case (state_r)
            ST_STOPPED: begin
                if (bus.timebase_en) begin
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (bus.timebase_en) begin
                    state_nxt_s = ST_RUNNING;
                    run_s       = 1'b1;
                    stopped_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            default: begin
                state_nxt_s = ST_STOPPED;
            end
        endcase
    end

    // Prescaler; ">=" lets the count recover when prescale_reg is lowered under it
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            prescale_cnt_r <= CNT_ZERO;
            sync_pulse_r   <= 1'b0;
        end else if (!run_s) begin
            prescale_cnt_r <= CNT_ZERO;
            sync_pulse_r   <= 1'b0;
        end else if (prescale_cnt_r >= bus.prescale_reg) begin
            prescale_cnt_r <= CNT_ZERO;
            sync_pulse_r   <= 1'b1;
        end else begin
            prescale_cnt_r <= prescale_cnt_r + CNT_ONE;
            sync_pulse_r   <= 1'b0;
        end
    end

    // Period counter advances after each sync so it is stable while sync_pulse is high
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            period_cnt_r <= CNT_ZERO;
        end else if (!run_s) begin
            period_cnt_r <= CNT_ZERO;
        end else if (sync_pulse_r) begin
            if (period_cnt_r >= bus.period_reg) begin
                period_cnt_r <= CNT_ZERO;
            end else begin
                period_cnt_r <= period_cnt_r + CNT_ONE;
            end
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end

    assign period_end_s = sync_pulse_r & (period_cnt_r >= bus.period_reg);

    // Load decision: immediate mode copies every edge; synchronized mode waits for period end or stop
    always_comb begin
        load_s        = 1'b0;
        pending_nxt_s = 1'b0;
        if (bus.update_mode) begin
            load_s = (update_pending_r | bus.sync_update_req) & (period_end_s | stopped_s);
            if (load_s) begin
                pending_nxt_s = 1'b0;
            end else begin
                pending_nxt_s = update_pending_r | bus.sync_update_req;
            end
        end else begin
            load_s        = 1'b1;
            pending_nxt_s = 1'b0;
        end
    end

    // Pending flag; repeated requests simply keep it set
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            update_pending_r <= 1'b0;
        end else begin
            update_pending_r <= pending_nxt_s;
        end
    end

    // Active channel registers take the staged values only on a load edge
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            enable_r  <= {PWM_NUM{1'b0}};
            posedge_r <= {(PWM_NUM*APB_DWIDTH){1'b0}};
            negedge_r <= {(PWM_NUM*APB_DWIDTH){1'b0}};
        end else if (load_s) begin
            enable_r  <= bus.stg_enable;
            posedge_r <= bus.stg_posedge;
            negedge_r <= bus.stg_negedge;
        end else begin
            enable_r  <= enable_r;
            posedge_r <= posedge_r;
            negedge_r <= negedge_r;
        end
    end

    assign bus.period_cnt      = period_cnt_r;
    assign bus.sync_pulse      = sync_pulse_r;
    assign bus.period_end      = period_end_s;
    assign bus.pwm_enable_reg  = enable_r;
    assign bus.pwm_posedge_reg = posedge_r;
    assign bus.pwm_negedge_reg = negedge_r;
    assign bus.update_pending  = update_pending_r;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed bench for pwm_timebase_ctrl: basic timebase, synchronized and
// immediate updates, period shrink, simultaneous events, disable and
// asynchronous reset mid-run.
module tb_pwm_timebase_ctrl;
    logic PCLK;
    logic PRESETN;
    int   checks;
    int   errors;

    pwm_timebase_ctrl_if #(.PWM_NUM(8), .APB_DWIDTH(8)) bus ();

    pwm_timebase_ctrl #(.PWM_NUM(8), .APB_DWIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},  {56'd0, bus.period_cnt}, 64'd0);
        chk({tag, "_sync"}, {63'd0, bus.sync_pulse}, 64'd0);
        chk({tag, "_pe"},   {63'd0, bus.period_end}, 64'd0);
        chk({tag, "_pend"}, {63'd0, bus.update_pending}, 64'd0);
        chk({tag, "_en"},   {56'd0, bus.pwm_enable_reg}, 64'd0);
        chk({tag, "_pos"},  bus.pwm_posedge_reg, 64'd0);
        chk({tag, "_neg"},  bus.pwm_negedge_reg, 64'd0);
    endtask

    initial begin
        logic [15:0] exp_sync_v;
        logic [15:0] exp_pe_v;
        int          exp_cnt [16];

        checks = 0;
        errors = 0;
        exp_sync_v = 16'b1001_0010_0100_1000;
        exp_pe_v   = 16'b0001_0000_0000_0000;
        exp_cnt    = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};

        PRESETN             = 1'b0;
        bus.timebase_en     = 1'b0;
        bus.prescale_reg    = 8'd2;
        bus.period_reg      = 8'd3;
        bus.update_mode     = 1'b0;
        bus.sync_update_req = 1'b0;
        bus.stg_enable      = 8'h00;
        bus.stg_posedge     = 64'd0;
        bus.stg_negedge     = 64'd0;

        // Reset state
        #3;
        chk_all_zero("reset");
        #9;
        PRESETN         = 1'b1;
        bus.timebase_en = 1'b1;

        // Basic timebase: edges 0..15
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("base_sync_e%0d", k), {63'd0, bus.sync_pulse}, {63'd0, exp_sync_v[k]});
            chk($sformatf("base_cnt_e%0d", k),  {56'd0, bus.period_cnt}, 64'(exp_cnt[k]));
            chk($sformatf("base_pe_e%0d", k),   {63'd0, bus.period_end}, {63'd0, exp_pe_v[k]});
        end

        // Synchronized update requested while period_cnt=1
        bus.update_mode = 1'b1;
        bus.stg_posedge = 64'h0000_0000_0000_0010;
        tick(); // edge 16
        chk("sync_cnt_at_req", {56'd0, bus.period_cnt}, 64'd1);
        chk("sync_pos_hold16", bus.pwm_posedge_reg, 64'd0);
        bus.sync_update_req = 1'b1;
        tick(); // edge 17
        bus.sync_update_req = 1'b0;
        for (int k = 17; k <= 24; k++) begin
            chk($sformatf("sync_pend_e%0d", k), {63'd0, bus.update_pending}, 64'd1);
            chk($sformatf("sync_pos_e%0d", k),  bus.pwm_posedge_reg, 64'd0);
            if (k < 24) tick();
        end
        chk("sync_pe_e24", {63'd0, bus.period_end}, 64'd1);
        chk("sync_cnt_e24", {56'd0, bus.period_cnt}, 64'd3);
        tick(); // edge 25
        chk("sync_pos_loaded", bus.pwm_posedge_reg, 64'h10);
        chk("sync_pend_clr", {63'd0, bus.update_pending}, 64'd0);
        chk("sync_cnt_e25", {56'd0, bus.period_cnt}, 64'd0);

        // Request in the same cycle as period_end
        bus.stg_posedge = 64'h0000_0000_0000_0020;
        repeat (11) tick(); // edge 36
        chk("simul_pe_e36", {63'd0, bus.period_end}, 64'd1);
        chk("simul_pos_hold", bus.pwm_posedge_reg, 64'h10);
        bus.sync_update_req = 1'b1;
        tick(); // edge 37
        bus.sync_update_req = 1'b0;
        chk("simul_pos_loaded", bus.pwm_posedge_reg, 64'h20);
        chk("simul_pend", {63'd0, bus.update_pending}, 64'd0);

        // Pending load, then drop timebase_en
        repeat (3) tick(); // edge 40
        chk("dis_cnt_e40", {56'd0, bus.period_cnt}, 64'd1);
        bus.stg_posedge     = 64'h0000_0000_0000_0030;
        bus.sync_update_req = 1'b1;
        tick(); // edge 41
        bus.sync_update_req = 1'b0;
        chk("dis_pend_set", {63'd0, bus.update_pending}, 64'd1);
        chk("dis_pos_hold", bus.pwm_posedge_reg, 64'h20);
        bus.timebase_en = 1'b0;
        tick(); // edge 42
        chk("dis_pos_loaded", bus.pwm_posedge_reg, 64'h30);
        chk("dis_pend_clr", {63'd0, bus.update_pending}, 64'd0);
        chk("dis_cnt_zero", {56'd0, bus.period_cnt}, 64'd0);
        chk("dis_sync_zero", {63'd0, bus.sync_pulse}, 64'd0);
        chk("dis_en_pre", {56'd0, bus.pwm_enable_reg}, 64'd0);

        // Immediate update; requests are ignored
        bus.update_mode     = 1'b0;
        bus.stg_enable      = 8'hA5;
        bus.sync_update_req = 1'b1;
        tick(); // edge 43
        chk("imm_enable", {56'd0, bus.pwm_enable_reg}, 64'hA5);
        chk("imm_pend0", {63'd0, bus.update_pending}, 64'd0);
        bus.stg_negedge = {8'h7E, 56'd0};
        tick(); // edge 44
        bus.sync_update_req = 1'b0;
        chk("imm_negedge", bus.pwm_negedge_reg, {8'h7E, 56'd0});
        chk("imm_pend1", {63'd0, bus.update_pending}, 64'd0);

        // Period shrink with prescale_reg=0
        bus.prescale_reg = 8'd0;
        bus.period_reg   = 8'd10;
        bus.timebase_en  = 1'b1;
        tick(); // edge 45
        chk("shr_sync_e45", {63'd0, bus.sync_pulse}, 64'd0);
        tick(); // edge 46
        chk("shr_sync_e46", {63'd0, bus.sync_pulse}, 64'd1);
        chk("shr_cnt_e46", {56'd0, bus.period_cnt}, 64'd0);
        repeat (7) tick(); // edge 53
        chk("shr_cnt7", {56'd0, bus.period_cnt}, 64'd7);
        chk("shr_sync_e53", {63'd0, bus.sync_pulse}, 64'd1);
        chk("shr_pe_pre", {63'd0, bus.period_end}, 64'd0);
        bus.period_reg = 8'd2;
        #1;
        chk("shr_pe_now", {63'd0, bus.period_end}, 64'd1);
        tick(); // edge 54
        chk("shr_wrap0", {56'd0, bus.period_cnt}, 64'd0);
        chk("shr_pe_e54", {63'd0, bus.period_end}, 64'd0);
        tick();
        chk("shr_seq1", {56'd0, bus.period_cnt}, 64'd1);
        tick();
        chk("shr_seq2", {56'd0, bus.period_cnt}, 64'd2);
        chk("shr_pe_seq2", {63'd0, bus.period_end}, 64'd1);
        tick(); // edge 57
        chk("shr_seq0", {56'd0, bus.period_cnt}, 64'd0);

        // Asynchronous reset mid-run with a load pending
        bus.update_mode     = 1'b1;
        bus.prescale_reg    = 8'd2;
        bus.stg_posedge     = 64'h0000_0000_0000_0040;
        bus.sync_update_req = 1'b1;
        tick(); // edge 58
        bus.sync_update_req = 1'b0;
        chk("rst_pend_pre", {63'd0, bus.update_pending}, 64'd1);
        chk("rst_cnt_pre", {56'd0, bus.period_cnt}, 64'd1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk_all_zero("midrst");
        #3;
        PRESETN = 1'b1;
        tick();
        tick();
        chk("rel_sync_e1", {63'd0, bus.sync_pulse}, 64'd0);
        tick();
        chk("rel_sync_e2", {63'd0, bus.sync_pulse}, 64'd0);
        tick();
        chk("rel_sync_e3", {63'd0, bus.sync_pulse}, 64'd1);
        chk("rel_cnt_e3", {56'd0, bus.period_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
